// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy encoding and default widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    CntEmpty = 2'd0,
    CntOne   = 2'd1,
    CntFull  = 2'd2
  } count_e;

  localparam int unsigned DefDataW    = 32;
  localparam int unsigned DefPcW      = 32;
  // All-zero payload decodes as sll $0,$0,0.
  localparam logic [31:0] DefNopValue = 32'h0000_0000;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with enable, cleared by asynchronous active-high reset.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffer pipeline stage with valid/ready handshake, flush and clock enable.
// Optional stall/flush performance counters are built when PIPE_SKID_STAGE_PERF_EN is defined.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned          DATA_W    = DefDataW,
  parameter int unsigned          PC_W      = DefPcW,
  parameter logic [DATA_W-1:0]    NOP_VALUE = DATA_W'(DefNopValue),
  parameter int unsigned          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  count_e            count_q, count_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              push, pop;

  // Both handshake outputs decode only the occupancy register, so no
  // combinational path exists from out_ready to in_ready.
  assign in_ready  = (count_q != CntFull);
  assign out_valid = (count_q != CntEmpty);
  assign out_pc    = main_pc_q;
  assign out_data  = out_valid ? main_data_q : NOP_VALUE;

  assign push = in_valid & in_ready & clk_en;
  assign pop  = out_valid & out_ready & clk_en;

  always_comb begin
    count_d     = count_q;
    main_pc_d   = main_pc_q;
    main_data_d = main_data_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      count_d     = CntEmpty;
      main_pc_d   = '0;
      main_data_d = NOP_VALUE;
      skid_pc_d   = '0;
      skid_data_d = NOP_VALUE;
    end else begin
      case (count_q)
        CntEmpty: begin
          if (push) begin
            main_pc_d   = in_pc;
            main_data_d = in_data;
            count_d     = CntOne;
          end
        end
        CntOne: begin
          if (push && pop) begin
            main_pc_d   = in_pc;
            main_data_d = in_data;
          end else if (pop) begin
            count_d = CntEmpty;
          end else if (push) begin
            skid_pc_d   = in_pc;
            skid_data_d = in_data;
            count_d     = CntFull;
          end
        end
        CntFull: begin
          if (pop) begin
            main_pc_d   = skid_pc_q;
            main_data_d = skid_data_q;
            count_d     = CntOne;
          end
        end
        default: count_d = CntEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= CntEmpty;
      main_pc_q   <= '0;
      main_data_q <= NOP_VALUE;
      skid_pc_q   <= '0;
      skid_data_q <= NOP_VALUE;
    end else begin
      count_q     <= count_d;
      main_pc_q   <= main_pc_d;
      main_data_q <= main_data_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_SKID_STAGE_PERF_EN
  logic stall_en, flush_en;

  assign stall_en = out_valid & ~out_ready & clk_en;
  assign flush_en = flush & (count_q != CntEmpty);

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_en),
    .cnt   (stall_cnt)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush_en),
    .cnt   (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage; inputs change and outputs are sampled on negedge.
module tb_pipe_skid_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              clk_en;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef PIPE_SKID_STAGE_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
  logic        sat_en;
  logic [1:0]  sat_cnt;

  pipe_sat_counter #(
    .CNT_W (2)
  ) u_sat (
    .clk   (clk),
    .reset (reset),
    .en    (sat_en),
    .cnt   (sat_cnt)
  );
`endif

  pipe_skid_stage #(
    .DATA_W    (DATA_W),
    .PC_W      (PC_W),
    .NOP_VALUE ('0),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_data  (out_data)
`ifdef PIPE_SKID_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h0000_0100; in_data = 32'h8C01_0004;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++;
      $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
    checks++; if (out_pc !== 32'h0) begin errors++;
      $display("FAIL reset_out_pc: got %h expected 00000000", out_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    reset = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h8C01_0004) begin errors++;
      $display("FAIL reset_first_push: got v=%b d=%h expected v=1 d=8c010004", out_valid, out_data); end
    checks++; if (out_pc !== 32'h0000_0100) begin errors++;
      $display("FAIL reset_first_pc: got %h expected 00000100", out_pc); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++;
      $display("FAIL reset_drain: got v=%b d=%h expected v=0 d=00000000", out_valid, out_data); end
  endtask

  task automatic test_streaming();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = vals[0]; in_pc = 32'h1000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin errors++;
        $display("FAIL stream_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, vals[i]); end
      checks++; if (in_ready !== 1'b1) begin errors++;
        $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
      if (i < 2) begin
        in_data = vals[i+1]; in_pc = in_pc + 32'd4;
      end else begin
        in_valid = 1'b0;
      end
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL stream_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA0; in_pc = 32'h2000;
    step();
    checks++; if (out_data !== 32'hA0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_first: got d=%h rdy=%b expected d=a0 rdy=1", out_data, in_ready); end
    in_data = 32'hB0; in_pc = 32'h2004;
    step();
    checks++; if (in_ready !== 1'b0 || out_data !== 32'hA0) begin errors++;
      $display("FAIL bp_full: got d=%h rdy=%b expected d=a0 rdy=0", out_data, in_ready); end
    in_data = 32'hC0; in_pc = 32'h2008;
    step();
    checks++; if (in_ready !== 1'b0 || out_data !== 32'hA0 || out_pc !== 32'h2000) begin errors++;
      $display("FAIL bp_hold: got d=%h pc=%h rdy=%b expected d=a0 pc=2000 rdy=0", out_data, out_pc, in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== 32'hB0 || out_pc !== 32'h2004 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_second: got d=%h pc=%h rdy=%b expected d=b0 pc=2004 rdy=1", out_data, out_pc, in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hC0) begin errors++;
      $display("FAIL bp_third: got v=%b d=%h expected v=1 d=c0", out_valid, out_data); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush_stalled();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h01; in_pc = 32'h3000;
    step();
    in_data = 32'h02; in_pc = 32'h3004;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL flush_setup_full: got rdy=%b expected 0", in_ready); end
    flush = 1'b1; in_data = 32'hDD; in_pc = 32'h3008;
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_pc !== 32'h0) begin errors++;
      $display("FAIL flush_bubble: got v=%b d=%h pc=%h expected v=0 d=0 pc=0", out_valid, out_data, out_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || out_data === 32'hDD) begin errors++;
      $display("FAIL flush_dropped: got v=%b d=%h expected v=0 d=00000000", out_valid, out_data); end
  endtask

  task automatic test_clk_en();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h55; in_pc = 32'h4000;
    step();
    clk_en = 1'b0; in_data = 32'h66; in_pc = 32'h4004; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h55 || in_ready !== 1'b1) begin errors++;
        $display("FAIL clken_frozen[%0d]: got v=%b d=%h rdy=%b expected v=1 d=55 rdy=1", i, out_valid, out_data, in_ready); end
    end
    clk_en = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h66 || out_pc !== 32'h4004) begin errors++;
      $display("FAIL clken_resume: got v=%b d=%h pc=%h expected v=1 d=66 pc=4004", out_valid, out_data, out_pc); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL clken_drain: got %b expected 0", out_valid); end
  endtask

`ifdef PIPE_SKID_STAGE_PERF_EN
  task automatic test_perf();
    reset = 1'b1; sat_en = 1'b0;
    step();
    reset = 1'b0;
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || sat_cnt !== 2'd0) begin errors++;
      $display("FAIL perf_reset: got s=%0d f=%0d sat=%0d expected 0 0 0", stall_cnt, flush_cnt, sat_cnt); end
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77; in_pc = 32'h5000;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    checks++; if (stall_cnt !== 16'd5) begin errors++;
      $display("FAIL perf_stall: got %0d expected 5", stall_cnt); end
    // Freeze handshakes so the flush cycle does not also count as a stall.
    clk_en = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; clk_en = 1'b1; out_ready = 1'b1;
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd5) begin errors++;
      $display("FAIL perf_flush: got f=%0d s=%0d expected f=1 s=5", flush_cnt, stall_cnt); end
    sat_en = 1'b1;
    repeat (6) step();
    sat_en = 1'b0;
    checks++; if (sat_cnt !== 2'd3) begin errors++;
      $display("FAIL perf_saturate: got %0d expected 3", sat_cnt); end
  endtask
`endif

  initial begin
`ifdef PIPE_SKID_STAGE_PERF_EN
    sat_en = 1'b0;
`endif
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush_stalled();
    test_clk_en();
`ifdef PIPE_SKID_STAGE_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised, elastic successor to the fixed IF/ID stage register. Replaces the single stall/flush register with a 2-entry skid buffer that uses a valid/ready handshake.
- Carries one PC word plus one payload word (instruction or bundled control) between any two pipeline stages.
- Lets downstream back-pressure take effect without combinational ready paths crossing the stage.
- Flush injects a bubble carrying a NOP payload.

Parameters:
- DATA_W, 32, payload width in bits (instruction word or packed control bundle).
- PC_W, 32, width of the PC+4 field.
- NOP_VALUE, 0, payload presented while out_valid=0 and after reset/flush (all-zero = sll $0,$0,0).
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  stage clock.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  global advance enable (debug single-step); 0 freezes all state except flush.
- flush  in  1  discard all held and incoming entries this cycle.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered, equals (count<2).
- in_pc  in  PC_W  upstream PC+4.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head (deasserted = stall).
- out_pc  out  PC_W  head PC+4.
- out_data  out  DATA_W  head payload; NOP_VALUE when out_valid=0.

Behaviour:
- Storage: main register (head, drives outputs) and skid register. State = count: EMPTY(0), ONE(1), FULL(2).
- Clock/reset: reset is asynchronous and active-high; clock is clk.
- Reset values: out_valid=0, out_pc=0, out_data=NOP_VALUE, skid contents 0/NOP_VALUE, count=EMPTY, in_ready=1.
- Transfers: push = in_valid & in_ready & clk_en; pop = out_valid & out_ready & clk_en. No transfer occurs when clk_en=0.
- Priority: reset > flush > clk_en/handshake.
- Flush: acts regardless of clk_en and out_ready. Next cycle count=EMPTY, out_valid=0, out_pc=0, out_data=NOP_VALUE. A push in the flush cycle is dropped. The previous generation ignored flush while stalled; here flush always wins.
- EMPTY: push -> load main, ONE. Latency in->out is exactly 1 cycle.
- ONE: push&pop -> main<=in, stay ONE. pop only -> EMPTY. push only -> skid<=in, FULL.
- FULL: in_ready=0 so no push is possible. pop -> main<=skid, ONE.
- in_ready is a register output; it never depends combinationally on out_ready.
- Ordering: strict FIFO with no duplication or loss except on flush. Throughput is 1 entry/cycle while out_ready=1.
- Held outputs: out_pc/out_data stay stable while out_valid=1 and pop=0.
- Reset asserted mid-operation: all state clears immediately (asynchronous); held entries are lost.

Optional Feature:
- Macro PIPE_SKID_STAGE_PERF_EN.
- Defined: adds outputs stall_cnt[CNT_W] (increments each cycle out_valid=1 & out_ready=0 & clk_en) and flush_cnt[CNT_W] (increments each cycle flush=1 & count!=EMPTY). Both saturate at all-ones and are cleared by reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: count state encoding (EMPTY/ONE/FULL), default NOP_VALUE constant, default PC_W/DATA_W.
- One natural sub-module, pipe_sat_counter (saturating CNT_W counter with enable), instantiated twice under the macro. Everything else stays in one module.

Test Plan:
- Reset mid-stream: hold reset high with in_valid=1 in_data=0x8C010004 -> out_valid=0, out_data=0, in_ready=1. After release, push -> out_data=0x8C010004 one cycle later.
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on the next three cycles, in_ready constantly 1.
- Back-pressure: out_ready=0, push 0xA0 then 0xB0 -> in_ready=0 after the second push and 0xC0 is held off. Raise out_ready -> outputs 0xA0, 0xB0, then 0xC0 accepted, no loss.
- Flush while stalled: FULL with out_ready=0, pulse flush with in_valid=1 in_data=0xDD -> next cycle out_valid=0, out_data=NOP_VALUE, 0xDD never appears.
- clk_en=0 with in_valid=1 and out_ready=1 -> count, outputs and in_ready frozen. Re-enable -> normal transfer resumes.
- PERF_EN: 5 stall cycles then one flush while ONE -> stall_cnt=5, flush_cnt=1. With CNT_W=2, 6 stalls -> stall_cnt=3 (saturated).
